// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Column-scanning front end for a 4x4 matrix keypad. One column is driven low
// at a time; the row pins are synchronised and a single-key press is debounced
// before being presented as one-hot row/column codes.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   row_n[3:0] raw row pins (pulled up, low = connected to the driven column)
//   col_n[3:0] column drive, exactly one bit low at all times
//   key_r[3:0] one-hot row of the accepted key (0 until a key is accepted)
//   key_c[3:0] one-hot column of the accepted key (0 until a key is accepted)
//   key_valid  one-cycle strobe when a new debounced press is accepted
//   key_held   high from acceptance until the release has been debounced
//
// Output semantics: key_valid is a pure event strobe with no back-pressure.
// Downstream logic samples key_r/key_c in the cycle key_valid is high; the
// codes stay stable afterwards until the next accepted press.
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV        = 4800,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_r,
  output logic [3:0] key_c,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DEBOUNCE   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    col_idx, col_idx_nx;
  logic [DW-1:0] dwell_cnt, dwell_cnt_nx;
  logic [BW-1:0] db_cnt, db_cnt_nx;
  logic [3:0]    cap_row, cap_row_nx;
  logic [3:0]    key_r_nx, key_c_nx;
  logic          key_valid_nx, key_held_nx;

  logic [3:0]    row_sync1, row_sync2;
  logic [3:0]    row_act;
  logic          row_single;
  logic          cap_active;

  // Two-flop synchroniser; idle level is all-ones (rows pulled up).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_sync1 <= 4'hF;
      row_sync2 <= 4'hF;
    end else begin
      row_sync1 <= row_n;
      row_sync2 <= row_sync1;
    end
  end

  assign row_act    = ~row_sync2;
  // Exactly one row active; two or more rows on one column is ambiguous.
  assign row_single = (row_act != 4'b0000) && ((row_act & (row_act - 4'd1)) == 4'b0000);
  // Only the captured row matters once a key is accepted.
  assign cap_active = |(row_act & cap_row);

  assign col_n = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      dwell_cnt <= '0;
      db_cnt    <= '0;
      cap_row   <= 4'b0000;
      key_r     <= 4'b0000;
      key_c     <= 4'b0000;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nx;
      col_idx   <= col_idx_nx;
      dwell_cnt <= dwell_cnt_nx;
      db_cnt    <= db_cnt_nx;
      cap_row   <= cap_row_nx;
      key_r     <= key_r_nx;
      key_c     <= key_c_nx;
      key_valid <= key_valid_nx;
      key_held  <= key_held_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    col_idx_nx   = col_idx;
    dwell_cnt_nx = dwell_cnt;
    db_cnt_nx    = db_cnt;
    cap_row_nx   = cap_row;
    key_r_nx     = key_r;
    key_c_nx     = key_c;
    key_valid_nx = 1'b0;
    key_held_nx  = key_held;

    case (state)
      SCAN: begin
        // Rows are only trusted on the last dwell cycle, after the
        // synchroniser has flushed the previous column's value.
        if (dwell_cnt == DWELL_LAST) begin
          dwell_cnt_nx = '0;
          if (row_single) begin
            cap_row_nx = row_act;
            db_cnt_nx  = '0;
            state_nx   = DEBOUNCE;
          end else begin
            col_idx_nx = col_idx + 2'd1;
          end
        end else begin
          dwell_cnt_nx = dwell_cnt + DW'(1);
        end
      end

      DEBOUNCE: begin
        if (row_act == cap_row) begin
          if (db_cnt == DB_LAST) begin
            key_r_nx     = cap_row;
            key_c_nx     = 4'b0001 << col_idx;
            key_valid_nx = 1'b1;
            key_held_nx  = 1'b1;
            db_cnt_nx    = '0;
            state_nx     = HELD;
          end else begin
            db_cnt_nx = db_cnt + BW'(1);
          end
        end else begin
          // Bounce or a second row joined in: give up on this column.
          col_idx_nx   = col_idx + 2'd1;
          dwell_cnt_nx = '0;
          state_nx     = SCAN;
        end
      end

      HELD: begin
        if (!cap_active) begin
          db_cnt_nx = '0;
          state_nx  = RELEASE_DB;
        end
      end

      RELEASE_DB: begin
        if (!cap_active) begin
          if (db_cnt == DB_LAST) begin
            key_held_nx  = 1'b0;
            col_idx_nx   = col_idx + 2'd1;
            dwell_cnt_nx = '0;
            db_cnt_nx    = '0;
            state_nx     = SCAN;
          end else begin
            db_cnt_nx = db_cnt + BW'(1);
          end
        end else begin
          // Release bounce: the key is still considered held, no new strobe.
          state_nx = HELD;
        end
      end

      default: state_nx = SCAN;
    endcase
  end

endmodule
